// File: rtl/apb_slave_pkg.sv
// Shared types and helpers for the APB3 memory completer.
package apb_slave_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_slv_state_e;

  // Wait-state counter width; WAIT_CYCLES must fit in it.
  localparam int unsigned WAIT_W = 4;

  // True when a (zero-extended) address selects an implemented memory word.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/apb_slave_ram.sv
// DEPTH x DW single-port register array: asynchronous read, synchronous write, reset-clear.
module apb_slave_ram #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IW    = 6
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [IW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [IW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o_c
);

  logic [DW-1:0] mem_q [DEPTH];

  // Combinational read port; callers gate out-of-range indices themselves.
  assign rdata_o_c = mem_q[raddr_i];

  // Write port with whole-array clear on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a local register memory, with fixed wait states and
// an error response for addresses beyond the implemented depth.
module apb_slave_mem
  import apb_slave_pkg::*;
#(
  parameter int unsigned AW          = 8,
  parameter int unsigned DW          = 8,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic          pclk_i,
  input  logic          preset_i,
  input  logic          psel_i,
  input  logic          penable_i,
  input  logic          pwrite_i,
  input  logic [AW-1:0] paddr_i,
  input  logic [DW-1:0] pwdata_i,
  output logic [DW-1:0] prdata_o,
  output logic          pready_o,
  output logic          pslverr_o
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Reject parameter sets the counter or address decode cannot represent.
  if (WAIT_CYCLES > 15 || (AW < 32 && DEPTH > (32'd1 << AW))) begin : g_param_check
    $error("apb_slave_mem: WAIT_CYCLES must be <= 15 and DEPTH <= 2**AW");
  end

  apb_slv_state_e      state_q;
  logic [AW-1:0]       addr_q;
  logic                write_q;
  logic [DW-1:0]       wdata_q;
  logic [WAIT_W-1:0]   cnt_q;
  logic                pready_q;
  logic [DW-1:0]       prdata_q;
  logic                pslverr_q;

  logic                setup_c;
  logic                access_c;
  logic [AW-1:0]       rd_addr_c;
  logic                rd_is_read_c;
  logic                rd_in_range_c;
  logic [DW-1:0]       rd_data_c;
  logic [DW-1:0]       rsp_data_c;
  logic                wr_en_c;

  // Bus phase decode and response-data selection. In IDLE the response (only
  // needed when there are no wait states) is formed from the bus; afterwards
  // only the values latched at SETUP are used.
  always_comb begin
    setup_c       = (state_q == IDLE) && psel_i && !penable_i;
    access_c      = psel_i && penable_i;
    rd_addr_c     = (state_q == IDLE) ? paddr_i : addr_q;
    rd_is_read_c  = (state_q == IDLE) ? !pwrite_i : !write_q;
    rd_in_range_c = addr_in_range(32'(rd_addr_c), DEPTH);
    rsp_data_c    = (rd_is_read_c && rd_in_range_c) ? rd_data_c : '0;
    wr_en_c       = (state_q == ACCESS) && pready_q && access_c && write_q
                    && addr_in_range(32'(addr_q), DEPTH);
  end

  apb_slave_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_ram (
    .clk_i     (pclk_i),
    .rst_i     (preset_i),
    .we_i      (wr_en_c),
    .waddr_i   (IW'(addr_q)),
    .wdata_i   (wdata_q),
    .raddr_i   (IW'(rd_addr_c)),
    .rdata_o_c (rd_data_c)
  );

  // Transfer FSM with latched request, wait counter and registered response.
  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (setup_c) begin
            state_q <= ACCESS;
            addr_q  <= paddr_i;
            write_q <= pwrite_i;
            wdata_q <= pwdata_i;
            cnt_q   <= WAIT_W'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              pready_q  <= 1'b1;
              prdata_q  <= rsp_data_c;
              pslverr_q <= !rd_in_range_c;
            end
          end
        end
        ACCESS: begin
          if (!psel_i || (access_c && pready_q)) begin
            // Abort or completion: drop back to IDLE with a quiet bus.
            state_q   <= IDLE;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
          end else if (access_c) begin
            cnt_q <= cnt_q - WAIT_W'(1);
            if (cnt_q == WAIT_W'(1)) begin
              pready_q  <= 1'b1;
              prdata_q  <= rsp_data_c;
              pslverr_q <= !rd_in_range_c;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign prdata_o  = prdata_q;
  assign pready_o  = pready_q;
  assign pslverr_o = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: two instances (2 and 0 wait states) on a shared bus,
// directed scenarios followed by random traffic against an array model.
module tb_apb_slave_mem;

  logic       pclk = 1'b0;
  logic       preset;
  logic       psel0, psel1, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic [7:0] prdata0, prdata1;
  logic       pready0, pready1, pslverr0, pslverr1;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem_m [2][64];
  int         waits [2] = '{2, 0};

  always #5 pclk = ~pclk;

  apb_slave_mem #(.AW(8), .DW(8), .DEPTH(64), .WAIT_CYCLES(2)) u_dut0 (
    .pclk_i(pclk), .preset_i(preset), .psel_i(psel0), .penable_i(penable),
    .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata),
    .prdata_o(prdata0), .pready_o(pready0), .pslverr_o(pslverr0));

  apb_slave_mem #(.AW(8), .DW(8), .DEPTH(64), .WAIT_CYCLES(0)) u_dut1 (
    .pclk_i(pclk), .preset_i(preset), .psel_i(psel1), .penable_i(penable),
    .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata),
    .prdata_o(prdata1), .pready_o(pready1), .pslverr_o(pslverr1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? pready0 : pready1;
  endfunction

  function automatic logic [7:0] rdat(input int d);
    return (d == 0) ? prdata0 : prdata1;
  endfunction

  function automatic logic err(input int d);
    return (d == 0) ? pslverr0 : pslverr1;
  endfunction

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_sel(input int d, input logic v);
    psel0 = (d == 0) ? v : 1'b0;
    psel1 = (d == 1) ? v : 1'b0;
  endtask

  task automatic bus_idle(input int cycles);
    set_sel(0, 1'b0);
    penable = 1'b0;
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic setup_phase(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd);
    paddr   = a;
    pwrite  = wr;
    pwdata  = wd;
    penable = 1'b0;
    set_sel(d, 1'b1);
    step();
    penable = 1'b1;
  endtask

  // Full transfer; optionally disturbs addr/data on the bus during ACCESS.
  task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                      input bit chg, input logic [7:0] ca, input logic [7:0] cd, input string tag);
    logic [7:0] exp_rd;
    logic       exp_err;
    int         n;
    bit         done;
    exp_err = (a >= 8'd64);
    exp_rd  = exp_err ? 8'h00 : mem_m[d][a[5:0]];
    setup_phase(d, wr, a, wd);
    if (chg) begin
      paddr  = ca;
      pwdata = cd;
    end
    n    = 1;
    done = 1'b0;
    while (!done && n <= 20) begin
      if (rdy(d)) begin
        chk({tag, "_latency"}, n, waits[d] + 1);
        if (!wr) chk({tag, "_prdata"}, rdat(d), exp_rd);
        chk({tag, "_pslverr"}, err(d), exp_err);
        done = 1'b1;
      end else begin
        chk({tag, "_wait_quiet"}, {rdat(d), err(d)}, 9'h0);
        step();
        n++;
      end
    end
    if (!done) chk({tag, "_timeout"}, n, waits[d] + 1);
    step();
    if (done && wr && !exp_err) mem_m[d][a[5:0]] = wd;
    chk({tag, "_after"}, {rdy(d), rdat(d), err(d)}, 10'h0);
    set_sel(d, 1'b0);
    penable = 1'b0;
  endtask

  initial begin
    logic [7:0] a, wd;
    int         d;
    bit         wr;
    int         n;

    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 64; j++) mem_m[i][j] = 8'h00;

    preset  = 1'b1;
    psel0   = 1'b0;
    psel1   = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 8'h00;
    pwdata  = 8'h00;
    step();
    step();
    preset = 1'b0;
    step();
    chk("reset_dut0", {pready0, prdata0, pslverr0}, 10'h0);
    chk("reset_dut1", {pready1, prdata1, pslverr1}, 10'h0);
    bus_idle(2);
    chk("idle_dut0", {pready0, prdata0, pslverr0}, 10'h0);

    // Basic read, then write/read back-to-back.
    xfer(0, 1'b0, 8'h05, 8'h00, 1'b0, 8'h00, 8'h00, "rd05");
    bus_idle(1);
    xfer(0, 1'b1, 8'h10, 8'hA5, 1'b0, 8'h00, 8'h00, "wr10");
    xfer(0, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00, 8'h00, "rd10");

    // Out-of-range accesses must error and leave memory alone.
    xfer(0, 1'b1, 8'h40, 8'h3C, 1'b0, 8'h00, 8'h00, "wr40_oor");
    xfer(0, 1'b0, 8'h40, 8'h00, 1'b0, 8'h00, 8'h00, "rd40_oor");
    xfer(0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, "rd00");

    // Zero-wait-state instance.
    xfer(1, 1'b1, 8'h01, 8'h11, 1'b0, 8'h00, 8'h00, "w0_wr01");
    xfer(1, 1'b0, 8'h01, 8'h00, 1'b0, 8'h00, 8'h00, "w0_rd01");

    // Bus disturbance during ACCESS is ignored.
    xfer(0, 1'b1, 8'h20, 8'h5A, 1'b1, 8'h22, 8'hFF, "wr20_chg");
    xfer(0, 1'b0, 8'h20, 8'h00, 1'b0, 8'h00, 8'h00, "rd20");
    xfer(0, 1'b0, 8'h22, 8'h00, 1'b0, 8'h00, 8'h00, "rd22");

    // Abort: psel dropped during the wait of a write.
    setup_phase(0, 1'b1, 8'h30, 8'h77);
    chk("abort_wait", pready0, 1'b0);
    set_sel(0, 1'b0);
    penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_quiet", {pready0, prdata0, pslverr0}, 10'h0);
    end
    xfer(0, 1'b0, 8'h30, 8'h00, 1'b0, 8'h00, 8'h00, "rd30_after_abort");

    // Reset while a read response is being presented.
    setup_phase(0, 1'b0, 8'h10, 8'h00);
    n = 0;
    while (!pready0 && n < 20) begin
      step();
      n++;
    end
    chk("rst_pre_rdy", {pready0, prdata0}, {1'b1, mem_m[0][16]});
    #2 preset = 1'b1;
    #1 chk("rst_async_clear", {pready0, prdata0, pslverr0}, 10'h0);
    set_sel(0, 1'b0);
    penable = 1'b0;
    step();
    preset = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 64; j++) mem_m[i][j] = 8'h00;
    xfer(0, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00, 8'h00, "rd10_after_rst");
    xfer(0, 1'b1, 8'h11, 8'hC3, 1'b0, 8'h00, 8'h00, "wr11_after_rst");
    xfer(0, 1'b0, 8'h11, 8'h00, 1'b0, 8'h00, 8'h00, "rd11_after_rst");

    // Random traffic on both instances, mixing back-to-back and idle gaps.
    for (int k = 0; k < 80; k++) begin
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 79));
      wd = 8'($urandom_range(0, 255));
      xfer(d, wr, a, wd, 1'b0, 8'h00, 8'h00, "rand");
      if ($urandom_range(0, 2) == 0) bus_idle(int'($urandom_range(1, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
